mem_loader: RTL and testbench

//  Writer-side counterpart to the read-only program memory: streams words over a

---
 rtl/mem_loader_pkg.sv | 12 +
 rtl/mem_loader_if.sv | 24 ++
 rtl/mod_sum_acc.sv | 23 ++
 rtl/mem_loader.sv | 143 ++++++++++++++
 tb/tb_mem_loader.sv | 346 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_loader_pkg.sv
// rtl/mem_loader_pkg.sv - shared types for the program-memory loader
package mem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WRITE  = 3'd1,
        ST_RDBACK = 3'd2,
        ST_CHECK  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

endpackage

// File: rtl/mem_loader_if.sv
// rtl/mem_loader_if.sv - word stream and RAM bus between source, loader and RAM
interface mem_loader_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic [DATA_WIDTH-1:0] i_data;
    logic                  i_valid;
    logic                  o_ready;
    logic [ADDR_WIDTH-1:0] o_mem_addr;
    logic                  o_mem_we;
    logic [DATA_WIDTH-1:0] o_mem_wdata;
    logic                  o_mem_re;
    logic [DATA_WIDTH-1:0] i_mem_rdata;

    modport slave (
        input  i_data, i_valid, i_mem_rdata,
        output o_ready, o_mem_addr, o_mem_we, o_mem_wdata, o_mem_re
    );

    modport master (
        output i_data, i_valid, i_mem_rdata,
        input  o_ready, o_mem_addr, o_mem_we, o_mem_wdata, o_mem_re
    );
endinterface

// File: rtl/mod_sum_acc.sv
// rtl/mod_sum_acc.sv - clearable modulo-2^DATA_WIDTH running sum
module mod_sum_acc #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_clear,
    input  logic                  i_add,
    input  logic [DATA_WIDTH-1:0] i_value,
    output logic [DATA_WIDTH-1:0] o_sum
);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_sum <= '0;
        end else if (i_clear) begin
            o_sum <= '0;
        end else if (i_add) begin
            o_sum <= o_sum + i_value;
        end
    end

endmodule

// File: rtl/mem_loader.sv
// rtl/mem_loader.sv - streams words into RAM from a base address, optional checksum read-back
module mem_loader
    import mem_loader_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int VERIFY     = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_base_addr,
    input  logic [ADDR_WIDTH:0]   i_count,
    mem_loader_if.slave           bus,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_error,
    output logic [DATA_WIDTH-1:0] o_checksum
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   CNT_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   COUNT_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   base_q, addr_q, addr_d;
    logic [ADDR_WIDTH:0]     count_q, remain_q, remain_d, count_sat;
    logic                    error_q, error_d;
    logic                    sum_clear, wr_add, rd_add;
    logic [DATA_WIDTH-1:0]   wsum, rsum;

    // Requests larger than the RAM can hold fill it exactly once.
    assign count_sat = (i_count > COUNT_MAX) ? COUNT_MAX : i_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= ST_IDLE;
            base_q   <= '0;
            count_q  <= '0;
            addr_q   <= '0;
            remain_q <= '0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            remain_q <= remain_d;
            error_q  <= error_d;
            if (state_q == ST_IDLE && i_start) begin
                base_q  <= i_base_addr;
                count_q <= count_sat;
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        remain_d        = remain_q;
        error_d         = error_q;
        sum_clear       = 1'b0;
        wr_add          = 1'b0;
        rd_add          = 1'b0;
        o_done          = 1'b0;
        bus.o_ready     = 1'b0;
        bus.o_mem_we    = 1'b0;
        bus.o_mem_re    = 1'b0;
        bus.o_mem_addr  = '0;
        bus.o_mem_wdata = '0;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    sum_clear = 1'b1;
                    error_d   = 1'b0;
                    addr_d    = i_base_addr;
                    remain_d  = count_sat;
                    state_d   = (count_sat == '0) ? ST_DONE : ST_WRITE;
                end
            end
            ST_WRITE: begin
                bus.o_ready    = 1'b1;
                bus.o_mem_addr = addr_q;
                if (bus.i_valid) begin
                    bus.o_mem_we    = 1'b1;
                    bus.o_mem_wdata = bus.i_data;
                    wr_add          = 1'b1;
                    addr_d          = addr_q + ADDR_ONE;
                    remain_d        = remain_q - CNT_ONE;
                    if (remain_q == CNT_ONE) begin
                        if (VERIFY != 0) begin
                            state_d  = ST_RDBACK;
                            addr_d   = base_q;
                            remain_d = count_q;
                        end else begin
                            state_d = ST_DONE;
                        end
                    end
                end
            end
            ST_RDBACK: begin
                bus.o_mem_re   = 1'b1;
                bus.o_mem_addr = addr_q;
                rd_add         = 1'b1;
                addr_d         = addr_q + ADDR_ONE;
                remain_d       = remain_q - CNT_ONE;
                if (remain_q == CNT_ONE) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                error_d = (rsum != wsum);
                state_d = ST_DONE;
            end
            ST_DONE: begin
                o_done  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    mod_sum_acc #(.DATA_WIDTH(DATA_WIDTH)) u_wsum (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clear (sum_clear),
        .i_add   (wr_add),
        .i_value (bus.i_data),
        .o_sum   (wsum)
    );

    mod_sum_acc #(.DATA_WIDTH(DATA_WIDTH)) u_rsum (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clear (sum_clear),
        .i_add   (rd_add),
        .i_value (bus.i_mem_rdata),
        .o_sum   (rsum)
    );

    assign o_busy     = (state_q != ST_IDLE);
    assign o_error    = error_q;
    assign o_checksum = wsum;

endmodule

// File: tb/tb_mem_loader.sv
// tb/tb_mem_loader.sv - scoreboard bench for mem_loader with a behavioural RAM
module tb_mem_loader;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int AS = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   count = '0;
    logic          busy, done, error;
    logic [DW-1:0] checksum;

    mem_loader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    mem_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .VERIFY(1)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (start),
        .i_base_addr (base_addr),
        .i_count     (count),
        .bus         (bus),
        .o_busy      (busy),
        .o_done      (done),
        .o_error     (error),
        .o_checksum  (checksum)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] ram [AS];
    logic          ram_clear = 1'b0;
    logic          corrupt_req = 1'b0;
    logic [AW-1:0] corrupt_addr = '0;

    always @(posedge clk) begin
        if (ram_clear) begin
            for (int i = 0; i < AS; i++) ram[i] <= '0;
        end else begin
            if (bus.o_mem_we) ram[bus.o_mem_addr] <= bus.o_mem_wdata;
            if (corrupt_req) ram[corrupt_addr] <= ram[corrupt_addr] ^ 8'h5A;
        end
    end

    assign bus.i_mem_rdata = ram[bus.o_mem_addr];

    int            vectors = 0;
    int            miscompares = 0;
    logic [DW-1:0] src [32];
    logic [AW+DW-1:0] exp_wr_q [$];
    logic [AW-1:0]    exp_rd_q [$];

    int            dc, nw, nr, nd;
    bit            ov;
    logic [DW-1:0] sm, exp_sum;
    logic          er;

    task automatic run_load(input logic [AW-1:0] b, input logic [AW:0] n, input int gap,
                            input bit corrupt, input bit glitch,
                            output int done_cyc, output int n_wr, output int n_rd,
                            output int n_done, output bit overlap,
                            output logic [DW-1:0] sum_at_done, output logic err_at_done);
        int eff, j;
        logic [AW+DW-1:0] e;
        logic [AW-1:0] ea;
        eff = (int'(n) > AS) ? AS : int'(n);
        exp_wr_q.delete();
        exp_rd_q.delete();
        for (int i = 0; i < eff; i++) begin
            exp_wr_q.push_back({AW'(b + i), src[i]});
            exp_rd_q.push_back(AW'(b + i));
        end
        done_cyc = -1; n_wr = 0; n_rd = 0; n_done = 0; overlap = 0;
        sum_at_done = '0; err_at_done = 1'b0; j = 0;
        @(negedge clk);
        base_addr = b; count = n; start = 1'b1; bus.i_valid = 1'b0;
        for (int k = 1; k <= 150; k++) begin
            @(negedge clk);
            corrupt_req = 1'b0;
            start = glitch && (k == 2);
            if (glitch && k == 2) base_addr = b + 4'd7;
            bus.i_valid = (j < eff) && (gap == 0 || (k - 1) % 3 == 0);
            bus.i_data  = (j < eff) ? src[j] : 8'hEE;
            #1;
            if (bus.o_mem_we && bus.o_mem_re) overlap = 1;
            if (bus.o_mem_we) begin
                n_wr++;
                vectors++;
                e = exp_wr_q.size() > 0 ? exp_wr_q.pop_front() : '1;
                if ({bus.o_mem_addr, bus.o_mem_wdata} !== e) begin
                    miscompares++;
                    $display("FAIL write_sb cyc %0d: got addr/data %h expected %h", k, {bus.o_mem_addr, bus.o_mem_wdata}, e);
                end
            end
            if (bus.o_mem_re) begin
                n_rd++;
                vectors++;
                ea = exp_rd_q.size() > 0 ? exp_rd_q.pop_front() : 'x;
                if (bus.o_mem_addr !== ea) begin
                    miscompares++;
                    $display("FAIL read_sb cyc %0d: got addr %h expected %h", k, bus.o_mem_addr, ea);
                end
                if (corrupt && n_rd == 1) begin
                    corrupt_req = 1'b1;
                    corrupt_addr = b + 4'd2;
                end
            end
            if (bus.i_valid && bus.o_ready) j++;
            if (done) begin
                n_done++;
                if (done_cyc < 0) begin
                    done_cyc = k;
                    sum_at_done = checksum;
                    err_at_done = error;
                end
            end
            if (done_cyc >= 0 && k >= done_cyc + 2) break;
        end
        corrupt_req = 1'b0;
        bus.i_valid = 1'b0;
        start = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        vectors++;
        if ({busy, done, error, checksum} !== '0) begin
            miscompares++;
            $display("FAIL reset_status: got %h expected 0", {busy, done, error, checksum});
        end
        vectors++;
        if ({bus.o_ready, bus.o_mem_we, bus.o_mem_re, bus.o_mem_addr, bus.o_mem_wdata} !== '0) begin
            miscompares++;
            $display("FAIL reset_bus: got %h expected 0", {bus.o_ready, bus.o_mem_we, bus.o_mem_re, bus.o_mem_addr, bus.o_mem_wdata});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        src[0] = 8'h11; src[1] = 8'h22; src[2] = 8'h33; src[3] = 8'h44;
        run_load(4'd0, 5'd4, 0, 1'b0, 1'b0, dc, nw, nr, nd, ov, sm, er);
        vectors++;
        if (dc !== 10) begin miscompares++; $display("FAIL basic_done_cycle: got %0d expected 10", dc); end
        vectors++;
        if (sm !== 8'hAA) begin miscompares++; $display("FAIL basic_checksum: got %h expected aa", sm); end
        vectors++;
        if (er !== 1'b0) begin miscompares++; $display("FAIL basic_error: got %b expected 0", er); end
        vectors++;
        if (nw !== 4 || nr !== 4 || nd !== 1 || ov) begin
            miscompares++;
            $display("FAIL basic_counts: got wr %0d rd %0d done %0d ovl %0d expected 4 4 1 0", nw, nr, nd, ov);
        end
        vectors++;
        if ({ram[0], ram[1], ram[2], ram[3]} !== 32'h11223344) begin
            miscompares++;
            $display("FAIL basic_ram: got %h expected 11223344", {ram[0], ram[1], ram[2], ram[3]});
        end
        vectors++;
        if ({busy, bus.o_mem_addr, bus.o_mem_wdata} !== '0) begin
            miscompares++;
            $display("FAIL basic_idle: got %h expected 0", {busy, bus.o_mem_addr, bus.o_mem_wdata});
        end
    endtask

    task automatic test_wrap();
        exp_sum = '0;
        for (int i = 0; i < 4; i++) begin
            src[i] = 8'hC0 + 8'(i * 17);
            exp_sum = exp_sum + src[i];
        end
        run_load(4'd14, 5'd4, 0, 1'b0, 1'b0, dc, nw, nr, nd, ov, sm, er);
        vectors++;
        if (dc !== 10 || nw !== 4 || nr !== 4) begin
            miscompares++;
            $display("FAIL wrap_timing: got done %0d wr %0d rd %0d expected 10 4 4", dc, nw, nr);
        end
        vectors++;
        if ({ram[14], ram[15], ram[0], ram[1]} !== {src[0], src[1], src[2], src[3]}) begin
            miscompares++;
            $display("FAIL wrap_ram: got %h expected %h", {ram[14], ram[15], ram[0], ram[1]}, {src[0], src[1], src[2], src[3]});
        end
        vectors++;
        if (sm !== exp_sum || er !== 1'b0) begin
            miscompares++;
            $display("FAIL wrap_sum: got %h err %b expected %h err 0", sm, er, exp_sum);
        end
    endtask

    task automatic test_gaps();
        src[0] = 8'h5A; src[1] = 8'hA5; src[2] = 8'h0F; src[3] = 8'hF0;
        run_load(4'd3, 5'd4, 1, 1'b0, 1'b0, dc, nw, nr, nd, ov, sm, er);
        vectors++;
        if (dc !== 16) begin miscompares++; $display("FAIL gaps_done_cycle: got %0d expected 16", dc); end
        vectors++;
        if (nw !== 4 || nd !== 1 || ov) begin
            miscompares++;
            $display("FAIL gaps_counts: got wr %0d done %0d ovl %0d expected 4 1 0", nw, nd, ov);
        end
        vectors++;
        if ({ram[3], ram[4], ram[5], ram[6]} !== 32'h5AA50FF0) begin
            miscompares++;
            $display("FAIL gaps_ram: got %h expected 5aa50ff0", {ram[3], ram[4], ram[5], ram[6]});
        end
        vectors++;
        if (sm !== 8'hFE) begin miscompares++; $display("FAIL gaps_checksum: got %h expected fe", sm); end
    endtask

    task automatic test_corrupt();
        src[0] = 8'h11; src[1] = 8'h22; src[2] = 8'h33; src[3] = 8'h44;
        run_load(4'd0, 5'd4, 0, 1'b1, 1'b0, dc, nw, nr, nd, ov, sm, er);
        vectors++;
        if (er !== 1'b1 || dc !== 10) begin
            miscompares++;
            $display("FAIL corrupt_error: got err %b done %0d expected 1 10", er, dc);
        end
        vectors++;
        if (error !== 1'b1) begin miscompares++; $display("FAIL corrupt_error_held: got %b expected 1", error); end
        vectors++;
        if (sm !== 8'hAA || ram[2] !== 8'h69) begin
            miscompares++;
            $display("FAIL corrupt_sum_ram: got %h %h expected aa 69", sm, ram[2]);
        end
    endtask

    task automatic test_count_zero();
        run_load(4'd9, 5'd0, 0, 1'b0, 1'b0, dc, nw, nr, nd, ov, sm, er);
        vectors++;
        if (nw !== 0 || nr !== 0 || nd !== 1) begin
            miscompares++;
            $display("FAIL zero_counts: got wr %0d rd %0d done %0d expected 0 0 1", nw, nr, nd);
        end
        vectors++;
        if (dc < 1 || dc > 2) begin miscompares++; $display("FAIL zero_done_cycle: got %0d expected 1..2", dc); end
        vectors++;
        if (er !== 1'b0 || error !== 1'b0 || sm !== 8'h00) begin
            miscompares++;
            $display("FAIL zero_error_cleared: got err %b/%b sum %h expected 0 0 00", er, error, sm);
        end
    endtask

    task automatic test_saturate();
        exp_sum = '0;
        for (int i = 0; i < AS; i++) begin
            src[i] = 8'(i * 3 + 1);
            exp_sum = exp_sum + src[i];
        end
        run_load(4'd5, 5'd20, 0, 1'b0, 1'b0, dc, nw, nr, nd, ov, sm, er);
        vectors++;
        if (nw !== 16 || nr !== 16 || dc !== 34) begin
            miscompares++;
            $display("FAIL sat_counts: got wr %0d rd %0d done %0d expected 16 16 34", nw, nr, dc);
        end
        vectors++;
        if (sm !== exp_sum || er !== 1'b0) begin
            miscompares++;
            $display("FAIL sat_sum: got %h err %b expected %h err 0", sm, er, exp_sum);
        end
        for (int i = 0; i < AS; i++) begin
            vectors++;
            if (ram[AW'(5 + i)] !== src[i]) begin
                miscompares++;
                $display("FAIL sat_ram[%0d]: got %h expected %h", (5 + i) % AS, ram[AW'(5 + i)], src[i]);
            end
        end
    endtask

    task automatic test_start_ignored();
        src[0] = 8'h01; src[1] = 8'h02; src[2] = 8'h03; src[3] = 8'h04;
        run_load(4'd0, 5'd4, 0, 1'b0, 1'b1, dc, nw, nr, nd, ov, sm, er);
        vectors++;
        if (dc !== 10 || nw !== 4 || nd !== 1 || sm !== 8'h0A) begin
            miscompares++;
            $display("FAIL start_ignored: got done %0d wr %0d pulses %0d sum %h expected 10 4 1 0a", dc, nw, nd, sm);
        end
    endtask

    task automatic test_reset_abort();
        logic [DW-1:0] saved;
        int late_we;
        saved = ram[10];
        late_we = 0;
        @(negedge clk);
        base_addr = 4'd8; count = 5'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0; bus.i_valid = 1'b1; bus.i_data = 8'hA1;
        @(negedge clk);
        bus.i_data = 8'hA2;
        @(negedge clk);
        rst_n = 1'b0; bus.i_data = 8'hA3;
        #1;
        vectors++;
        if ({busy, done, error, checksum} !== '0) begin
            miscompares++;
            $display("FAIL abort_status: got %h expected 0", {busy, done, error, checksum});
        end
        vectors++;
        if ({bus.o_ready, bus.o_mem_we, bus.o_mem_re, bus.o_mem_addr, bus.o_mem_wdata} !== '0) begin
            miscompares++;
            $display("FAIL abort_bus: got %h expected 0", {bus.o_ready, bus.o_mem_we, bus.o_mem_re, bus.o_mem_addr, bus.o_mem_wdata});
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            if (bus.o_mem_we) late_we++;
        end
        vectors++;
        if (late_we !== 0) begin miscompares++; $display("FAIL abort_no_write: got %0d writes expected 0", late_we); end
        vectors++;
        if ({ram[8], ram[9], ram[10]} !== {8'hA1, 8'hA2, saved}) begin
            miscompares++;
            $display("FAIL abort_ram: got %h expected %h", {ram[8], ram[9], ram[10]}, {8'hA1, 8'hA2, saved});
        end
        @(negedge clk);
        rst_n = 1'b1; bus.i_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        bus.i_valid = 1'b0;
        bus.i_data  = '0;
        ram_clear = 1'b1;
        test_reset();
        ram_clear = 1'b0;
        test_basic();
        test_wrap();
        test_gaps();
        test_corrupt();
        test_count_zero();
        test_saturate();
        test_start_ignored();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
